// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice manager between the MIDI event decoder
// and a bank of NUM_VOICES phase accumulators.
// Note-on picks a voice in this order: the same note already sounding, then a
// free voice, then the oldest sounding voice (stolen). Note-off releases the
// lowest-index voice holding that note. The chosen accumulator is configured
// with a one-cycle cfg_valid strobe.
// Optional feature macro: SUSTAIN_PEDAL_EN (adds the sustain input, holds
// released notes while the pedal is down and releases them when it lifts).
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int VIDX_W     = 3,
  parameter int FREQ_W     = 32,
  parameter int AGE_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                  sustain,
`endif
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [6:0]            ev_note,
  output logic [6:0]            rom_note,
  input  logic [FREQ_W-1:0]     rom_freq,
  output logic                  cfg_valid,
  output logic [VIDX_W-1:0]     cfg_voice,
  output logic [FREQ_W-1:0]     cfg_freq,
  output logic                  cfg_gate,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic                  steal_pulse
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RELEASE} state_t;

  state_t             state;
  logic               lat_on;
  logic [6:0]         lat_note;
  logic [VIDX_W-1:0]  scan_idx;
  logic [6:0]         notes [NUM_VOICES];
  logic [AGE_W-1:0]   ages  [NUM_VOICES];

  // running scan results: first same-note voice, first free voice, oldest voice
  logic               same_f, free_f, old_f;
  logic [VIDX_W-1:0]  same_i, free_i, old_i;
  logic [AGE_W-1:0]   old_age;

  logic               cur_act, cur_same, cur_old;
  logic               nx_same_f, nx_free_f;
  logic [VIDX_W-1:0]  nx_same_i, nx_free_i, nx_old_i;
  logic               hit, steal;
  logic [VIDX_W-1:0]  choice;
  logic               idle_ready;
  logic               hold_off;
  logic               last_scan;

  assign last_scan = (scan_idx == VIDX_W'(NUM_VOICES - 1));

`ifdef SUSTAIN_PEDAL_EN
  logic                  sustain_q;
  logic                  pending;
  logic                  lat_sus;
  logic                  fall;
  logic [NUM_VOICES-1:0] held_mask;
  logic [VIDX_W-1:0]     rel_idx;

  assign fall       = sustain_q & ~sustain;
  // a pending pedal release keeps the event port closed until serviced
  assign idle_ready = ~(pending | fall);
  assign hold_off   = ~lat_on & lat_sus;

  // lowest-index held voice, released first
  always_comb begin
    rel_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--)
      if (held_mask[i]) rel_idx = VIDX_W'(i);
  end
`else
  assign idle_ready = 1'b1;
  assign hold_off   = 1'b0;
`endif

  // fold the voice under examination into the running scan results
  always_comb begin
    cur_act   = active_mask[scan_idx];
    cur_same  = cur_act && (notes[scan_idx] == lat_note);
    cur_old   = cur_act && (!old_f || (ages[scan_idx] > old_age));
    nx_same_f = same_f | cur_same;
    nx_same_i = (!same_f && cur_same) ? scan_idx : same_i;
    nx_free_f = free_f | ~cur_act;
    nx_free_i = (!free_f && !cur_act) ? scan_idx : free_i;
    nx_old_i  = cur_old ? scan_idx : old_i;
    choice    = nx_same_i;
    hit       = nx_same_f;
    steal     = 1'b0;
    if (lat_on && !nx_same_f) begin
      hit = 1'b1;
      if (nx_free_f) begin
        choice = nx_free_i;
      end else begin
        choice = nx_old_i;
        steal  = 1'b1;
      end
    end
  end

  // allocation FSM, voice table and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ev_ready    <= 1'b0;
      lat_on      <= 1'b0;
      lat_note    <= '0;
      rom_note    <= '0;
      scan_idx    <= '0;
      same_f      <= 1'b0;
      free_f      <= 1'b0;
      old_f       <= 1'b0;
      same_i      <= '0;
      free_i      <= '0;
      old_i       <= '0;
      old_age     <= '0;
      cfg_valid   <= 1'b0;
      cfg_voice   <= '0;
      cfg_freq    <= '0;
      cfg_gate    <= 1'b0;
      steal_pulse <= 1'b0;
      active_mask <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        notes[i] <= '0;
        ages[i]  <= '0;
      end
`ifdef SUSTAIN_PEDAL_EN
      sustain_q <= 1'b0;
      pending   <= 1'b0;
      lat_sus   <= 1'b0;
      held_mask <= '0;
`endif
    end else begin
      cfg_valid   <= 1'b0;
      steal_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_valid && ev_ready) begin
            lat_on   <= ev_on;
            lat_note <= ev_note;
            rom_note <= ev_note;
            ev_ready <= 1'b0;
            scan_idx <= '0;
            same_f   <= 1'b0;
            free_f   <= 1'b0;
            old_f    <= 1'b0;
            state    <= SCAN;
`ifdef SUSTAIN_PEDAL_EN
            lat_sus  <= sustain;
`endif
          end else begin
            ev_ready <= idle_ready;
`ifdef SUSTAIN_PEDAL_EN
            if (pending) state <= RELEASE;
`endif
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          same_f   <= nx_same_f;
          same_i   <= nx_same_i;
          free_f   <= nx_free_f;
          free_i   <= nx_free_i;
          old_f    <= old_f | cur_old;
          old_i    <= nx_old_i;
          old_age  <= cur_old ? ages[scan_idx] : old_age;
          if (last_scan) begin
            if (hit && !hold_off) begin
              cfg_valid   <= 1'b1;
              cfg_voice   <= choice;
              cfg_gate    <= lat_on;
              cfg_freq    <= lat_on ? rom_freq : '0;
              steal_pulse <= steal;
              state       <= COMMIT;
            end else begin
`ifdef SUSTAIN_PEDAL_EN
              if (hit) held_mask[choice] <= 1'b1;
`endif
              ev_ready <= idle_ready;
              state    <= IDLE;
            end
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (VIDX_W'(i) == cfg_voice) begin
              active_mask[i] <= lat_on;
              ages[i]        <= '0;
              if (lat_on) notes[i] <= lat_note;
`ifdef SUSTAIN_PEDAL_EN
              if (lat_on) held_mask[i] <= 1'b0;
`endif
            end else if (lat_on && active_mask[i] && (ages[i] != '1)) begin
              ages[i] <= ages[i] + 1'b1;
            end
          end
          ev_ready <= idle_ready;
          state    <= IDLE;
        end
        default: begin
`ifdef SUSTAIN_PEDAL_EN
          if (|held_mask) begin
            cfg_valid            <= 1'b1;
            cfg_voice            <= rel_idx;
            cfg_gate             <= 1'b0;
            cfg_freq             <= '0;
            active_mask[rel_idx] <= 1'b0;
            held_mask[rel_idx]   <= 1'b0;
            ages[rel_idx]        <= '0;
          end else begin
            pending  <= 1'b0;
            ev_ready <= ~fall;
            state    <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
`ifdef SUSTAIN_PEDAL_EN
      sustain_q <= sustain;
      if (fall) pending <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation order, stealing, release,
// drop timing, mid-scan reset and (with SUSTAIN_PEDAL_EN) pedal release.
module tb_voice_allocator;
  localparam int NV = 8;
  localparam int VW = 3;
  localparam int FW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_on = 1'b0;
  logic [6:0]    ev_note = '0;
  logic [6:0]    rom_note;
  logic [FW-1:0] rom_freq = '0;
  logic          cfg_valid;
  logic [VW-1:0] cfg_voice;
  logic [FW-1:0] cfg_freq;
  logic          cfg_gate;
  logic [NV-1:0] active_mask;
  logic          steal_pulse;
`ifdef SUSTAIN_PEDAL_EN
  logic          sustain = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int            cv_cyc, rdy_cyc, cv_cnt;
  logic [VW-1:0] cv_voice;
  logic [FW-1:0] cv_freq;
  logic          cv_gate, cv_steal;
  logic [6:0]    rn;

  voice_allocator #(.NUM_VOICES(NV), .VIDX_W(VW), .FREQ_W(FW), .AGE_W(AW)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SUSTAIN_PEDAL_EN
    .sustain(sustain),
`endif
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_on(ev_on),
    .ev_note(ev_note),
    .rom_note(rom_note),
    .rom_freq(rom_freq),
    .cfg_valid(cfg_valid),
    .cfg_voice(cfg_voice),
    .cfg_freq(cfg_freq),
    .cfg_gate(cfg_gate),
    .active_mask(active_mask),
    .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] rom_lookup(input logic [6:0] n);
    case (n)
      7'd69:   return 32'd440;
      7'd72:   return 32'd523;
      default: return 32'(n) * 32'd10;
    endcase
  endfunction

  // registered frequency ROM
  always @(posedge clk) rom_freq <= rom_lookup(rom_note);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // issue one event from a negedge; returns at the negedge where ev_ready is back
  task automatic send(input logic on, input logic [6:0] note);
    int n;
    n = 0;
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) chk("ready_wait", {63'd0, ev_ready}, 64'd1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    @(negedge clk);
    ev_valid = 1'b0;
    cv_cyc = -1; rdy_cyc = -1; cv_cnt = 0; rn = rom_note;
    for (int c = 1; c <= 30; c++) begin
      if (cfg_valid) begin
        cv_cnt++;
        cv_cyc   = c;
        cv_voice = cfg_voice;
        cv_freq  = cfg_freq;
        cv_gate  = cfg_gate;
        cv_steal = steal_pulse;
      end
      if (ev_ready) begin
        rdy_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic note_on_chk(input string t, input logic [6:0] note, input int voice,
                             input int freq, input int stl, input int mask);
    send(1'b1, note);
    chk({t, "_cfg_cyc"}, 64'(cv_cyc), 64'd9);
    chk({t, "_voice"},   64'(cv_voice), 64'(voice));
    chk({t, "_freq"},    64'(cv_freq), 64'(freq));
    chk({t, "_gate"},    64'(cv_gate), 64'd1);
    chk({t, "_steal"},   64'(cv_steal), 64'(stl));
    chk({t, "_rdy_cyc"}, 64'(rdy_cyc), 64'd10);
    chk({t, "_mask"},    64'(active_mask), 64'(mask));
  endtask

  initial begin
    int cnt, first, second;
    logic [VW-1:0] v0, v1;
    logic gor;
    logic [FW-1:0] forr;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_ready", 64'(ev_ready), 64'd0);
    chk("rst_cfg_valid", 64'(cfg_valid), 64'd0);
    chk("rst_cfg_voice", 64'(cfg_voice), 64'd0);
    chk("rst_cfg_freq", 64'(cfg_freq), 64'd0);
    chk("rst_cfg_gate", 64'(cfg_gate), 64'd0);
    chk("rst_rom_note", 64'(rom_note), 64'd0);
    chk("rst_steal", 64'(steal_pulse), 64'd0);
    chk("rst_mask", 64'(active_mask), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rel_ready_low", 64'(ev_ready), 64'd0);
    @(negedge clk);
    chk("rel_ready_high", 64'(ev_ready), 64'd1);

    // 1: first note-on lands on voice 0
    note_on_chk("t1", 7'd69, 0, 440, 0, 8'h01);
    chk("t1_rom_note", 64'(rn), 64'd69);

    // 2: fill all voices, then steal the oldest
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 7'(60 + i));
      chk($sformatf("t2_fill%0d_voice", i), 64'(cv_voice), 64'(i));
      chk($sformatf("t2_fill%0d_freq", i), 64'(cv_freq), 64'((60 + i) * 10));
    end
    chk("t2_full_mask", 64'(active_mask), 64'hFF);
    note_on_chk("t2_steal", 7'd72, 0, 523, 1, 8'hFF);

    // 3: note-off releases, unknown note-off is dropped
    send(1'b0, 7'd64);
    chk("t3_off_voice", 64'(cv_voice), 64'd4);
    chk("t3_off_gate", 64'(cv_gate), 64'd0);
    chk("t3_off_freq", 64'(cv_freq), 64'd0);
    chk("t3_off_cyc", 64'(cv_cyc), 64'd9);
    chk("t3_off_mask", 64'(active_mask), 64'hEF);
    send(1'b0, 7'd100);
    chk("t3_drop_cnt", 64'(cv_cnt), 64'd0);
    chk("t3_drop_rdy", 64'(rdy_cyc), 64'd9);
    chk("t3_drop_mask", 64'(active_mask), 64'hEF);
    note_on_chk("t3_free", 7'd80, 4, 800, 0, 8'hFF);

    // 4: retrigger of a sounding note reuses its voice
    do_reset();
    send(1'b1, 7'd60);
    send(1'b1, 7'd61);
    send(1'b1, 7'd69);
    chk("t4_setup_voice", 64'(cv_voice), 64'd2);
    note_on_chk("t4_retrig", 7'd69, 2, 440, 0, 8'h07);

    // 5: reset during scan discards the event and clears the table
    do_reset();
    send(1'b1, 7'd60);
    chk("t5_setup_mask", 64'(active_mask), 64'h01);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd61;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_rst_ready", 64'(ev_ready), 64'd0);
    chk("t5_rst_mask", 64'(active_mask), 64'd0);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cfg_valid) cnt++;
      if (ev_ready) cnt++;
    end
    reset = 1'b0;
    #1 chk("t5_rel_ready_low", 64'(ev_ready), 64'd0);
    @(negedge clk);
    chk("t5_rel_ready_high", 64'(ev_ready), 64'd1);
    for (int c = 0; c < 12; c++) begin
      if (cfg_valid) cnt++;
      @(negedge clk);
    end
    chk("t5_no_cfg", 64'(cnt), 64'd0);
    chk("t5_mask", 64'(active_mask), 64'd0);

`ifdef SUSTAIN_PEDAL_EN
    // 6: held note-offs released one per cycle when the pedal lifts
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 7'(60 + i));
    sustain = 1'b1;
    send(1'b0, 7'd61);
    chk("t6_hold1_cnt", 64'(cv_cnt), 64'd0);
    chk("t6_hold1_rdy", 64'(rdy_cyc), 64'd9);
    send(1'b0, 7'd63);
    chk("t6_hold3_cnt", 64'(cv_cnt), 64'd0);
    chk("t6_hold_mask", 64'(active_mask), 64'h0F);
    sustain = 1'b0;
    @(negedge clk);
    chk("t6_ready_drop", 64'(ev_ready), 64'd0);
    cnt = 0; first = -1; second = -1; v0 = '0; v1 = '0; gor = 1'b0; forr = '0;
    for (int c = 0; c < 20; c++) begin
      if (cfg_valid) begin
        if (cnt == 0) begin first = c; v0 = cfg_voice; end
        else if (cnt == 1) begin second = c; v1 = cfg_voice; end
        cnt++;
        gor  = gor | cfg_gate;
        forr = forr | cfg_freq;
      end
      if (ev_ready) break;
      @(negedge clk);
    end
    chk("t6_rel_cnt", 64'(cnt), 64'd2);
    chk("t6_rel_v0", 64'(v0), 64'd1);
    chk("t6_rel_v1", 64'(v1), 64'd3);
    chk("t6_rel_consec", 64'(second - first), 64'd1);
    chk("t6_rel_gate", 64'(gor), 64'd0);
    chk("t6_rel_freq", 64'(forr), 64'd0);
    chk("t6_ready", 64'(ev_ready), 64'd1);
    chk("t6_mask", 64'(active_mask), 64'h05);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
